// File: rtl/risc_mem_arbiter.sv
// -----------------------------------------------------------------------------
// risc_mem_arbiter
//
// Purpose:
//   Shares the single-port unified program/data memory of the risc_16_bit core
//   between three requesters: the program loader/debug port (ldr), the data
//   LD/ST unit (dmem) and instruction fetch (imem). At most one access is issued
//   per cycle. Each read response is routed back to the port that issued it one
//   cycle later. A starvation counter forces fetch to the top priority after
//   STARVE_MAX consecutive denied fetch cycles. The loader may take exclusive
//   ownership of the memory with ldr_lock.
//
// Parameters:
//   AW         memory address width (default 8, 256 words)
//   DW         data/instruction word width (default 16)
//   STARVE_MAX denied imem cycles before imem is forced to top priority (1..15)
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   ldr_req/we/lock/addr/wdata     loader request, write enable, lock, address, data
//   ldr_gnt, ldr_rvalid            loader access issued, loader read data valid
//   dmem_req/we/addr/wdata         LD/ST request (we=1 ST, we=0 LD)
//   dmem_gnt, dmem_rvalid          LD/ST access issued, LD data valid
//   imem_req/addr                  fetch request and PC
//   imem_gnt, imem_rvalid          fetch issued, instruction valid
//   rdata                          shared read-return data (mem_rdata passthrough)
//   mem_en/we/addr/wdata           memory access strobe, write enable, address, data
//   mem_rdata                      memory read data, one cycle after a read strobe
//   locked                         loader exclusive lock active
//
// Optional feature (macro ARB_STATS_EN):
//   Adds saturating 16-bit counters ldr_cnt, dmem_cnt, imem_cnt (grants per
//   port) and stall_cnt (cycles imem requested but was not granted). Without
//   the macro these ports and counters do not exist and arbitration is the same.
// -----------------------------------------------------------------------------
module risc_mem_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic          ldr_lock,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic          ldr_gnt,
  output logic          ldr_rvalid,

  input  logic          dmem_req,
  input  logic          dmem_we,
  input  logic [AW-1:0] dmem_addr,
  input  logic [DW-1:0] dmem_wdata,
  output logic          dmem_gnt,
  output logic          dmem_rvalid,

  input  logic          imem_req,
  input  logic [AW-1:0] imem_addr,
  output logic          imem_gnt,
  output logic          imem_rvalid,

  output logic [DW-1:0] rdata,

  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,

`ifdef ARB_STATS_EN
  output logic [15:0]   ldr_cnt,
  output logic [15:0]   dmem_cnt,
  output logic [15:0]   imem_cnt,
  output logic [15:0]   stall_cnt,
`endif

  output logic          locked
);

  // Which port owns the read data returning in the current cycle.
  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_LDR  = 2'd1,
    TAG_DMEM = 2'd2,
    TAG_IMEM = 2'd3
  } tag_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  tag_e       tag_q;
  tag_e       tag_d;
  logic [3:0] starve_cnt;
  logic       starved;

  // ---------------------------------------------------------------------------
  // Grant selection. rst blocks every grant combinationally. While locked only
  // the loader may be served and the starvation override is suppressed.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves a signal unassigned and no latch is inferred.
    ldr_gnt  = 1'b0;
    dmem_gnt = 1'b0;
    imem_gnt = 1'b0;
    starved  = !locked && (starve_cnt == STARVE_LIM);

    if (!rst) begin
      if (locked) begin
        ldr_gnt = ldr_req;
      end else if (starved && imem_req) begin
        imem_gnt = 1'b1;
      end else if (ldr_req) begin
        ldr_gnt = 1'b1;
      end else if (dmem_req) begin
        dmem_gnt = 1'b1;
      end else if (imem_req) begin
        imem_gnt = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Memory-side mux and read tag for the response in the next cycle.
  // ---------------------------------------------------------------------------
  assign mem_en = ldr_gnt | dmem_gnt | imem_gnt;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    tag_d     = TAG_NONE;

    if (ldr_gnt) begin
      mem_we    = ldr_we;
      mem_addr  = ldr_addr;
      mem_wdata = ldr_wdata;
      tag_d     = ldr_we ? TAG_NONE : TAG_LDR;
    end else if (dmem_gnt) begin
      mem_we    = dmem_we;
      mem_addr  = dmem_addr;
      mem_wdata = dmem_wdata;
      tag_d     = dmem_we ? TAG_NONE : TAG_DMEM;
    end else if (imem_gnt) begin
      mem_addr  = imem_addr;
      tag_d     = TAG_IMEM;
    end
  end

  // ---------------------------------------------------------------------------
  // Arbiter state: response tag, starvation counter, loader lock.
  // The tag is loaded from the previous cycle's grant, so a read granted just
  // before rst still returns its rvalid during the rst cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      tag_q      <= TAG_NONE;
      starve_cnt <= '0;
      locked     <= 1'b0;
    end else begin
      tag_q <= tag_d;

      // Counting continues while locked so fetch wins as soon as the lock drops.
      if (imem_req && !imem_gnt) begin
        if (starve_cnt != STARVE_LIM) begin
          starve_cnt <= starve_cnt + 4'd1;
        end
      end else begin
        starve_cnt <= '0;
      end

      // Lock is taken by a granted locking loader access and held while
      // ldr_lock stays high.
      locked <= ldr_lock && (locked || ldr_gnt);
    end
  end

  assign ldr_rvalid  = (tag_q == TAG_LDR);
  assign dmem_rvalid = (tag_q == TAG_DMEM);
  assign imem_rvalid = (tag_q == TAG_IMEM);
  assign rdata       = mem_rdata;

`ifdef ARB_STATS_EN
  // ---------------------------------------------------------------------------
  // Saturating usage counters.
  // ---------------------------------------------------------------------------
  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      ldr_cnt   <= '0;
      dmem_cnt  <= '0;
      imem_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      ldr_cnt   <= sat_inc(ldr_cnt, ldr_gnt);
      dmem_cnt  <= sat_inc(dmem_cnt, dmem_gnt);
      imem_cnt  <= sat_inc(imem_cnt, imem_gnt);
      stall_cnt <= sat_inc(stall_cnt, imem_req && !imem_gnt);
    end
  end
`endif

endmodule

// File: doc/risc_mem_arbiter.md
Name: risc_mem_arbiter

Overview:
- Shares the single-port unified 16-bit program/data memory of the risc_16_bit core between three requesters:
  - program loader/debug port (ldr)
  - data LD/ST unit (dmem)
  - instruction fetch (imem)
- Issues at most one memory access per cycle.
- Routes each read response back to the port that issued it.
- A starvation counter guarantees fetch progress under continuous LD/ST or loader traffic.

Parameters:
- AW, 8, memory address width (256 words)
- DW, 16, data/instruction word width
- STARVE_MAX, 4, consecutive denied imem cycles before imem is forced to top priority (range 1..15)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ldr_req  in  1  loader access request
- ldr_we  in  1  loader write enable (1=write, 0=read)
- ldr_lock  in  1  loader requests exclusive memory ownership
- ldr_addr  in  AW  loader address
- ldr_wdata  in  DW  loader write data
- ldr_gnt  out  1  loader access issued this cycle
- ldr_rvalid  out  1  loader read data valid on rdata
- dmem_req  in  1  LD/ST request
- dmem_we  in  1  1=ST, 0=LD
- dmem_addr  in  AW  effective address
- dmem_wdata  in  DW  store data
- dmem_gnt  out  1  LD/ST access issued this cycle
- dmem_rvalid  out  1  LD data valid on rdata
- imem_req  in  1  fetch request
- imem_addr  in  AW  PC
- imem_gnt  out  1  fetch issued this cycle
- imem_rvalid  out  1  instruction valid on rdata
- rdata  out  DW  shared read-return data (mem_rdata passthrough)
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid 1 cycle after mem_en with mem_we=0
- locked  out  1  loader exclusive lock active

Behaviour:
- Handshake:
  - Requester holds req, we, addr and wdata stable until it sees gnt high in the same cycle.
  - gnt is combinational from the current req inputs and registered arbiter state.
  - Exactly one gnt, or none, per cycle.
  - mem_en equals the OR of all gnts; mem_we, mem_addr and mem_wdata are muxed from the granted port in the same cycle.
  - With no grant, mem_we=0 and mem_addr/mem_wdata=0.
- Read latency: for a granted read in cycle N, the matching *_rvalid is high in cycle N+1, with rdata=mem_rdata.
  - Issuing port is held in a 2-bit registered tag; tag=none for writes and idle cycles.
  - Writes never produce rvalid.
  - Back-to-back reads from different ports are allowed every cycle.
- Priority, normal: ldr > dmem > imem.
- Starvation:
  - 4-bit counter starve_cnt increments each cycle imem_req=1 and imem_gnt=0, saturating at STARVE_MAX.
  - Clears on imem_gnt or imem_req=0.
  - When starve_cnt==STARVE_MAX: priority becomes imem > ldr > dmem for that cycle.
- Lock:
  - locked sets on the edge after a cycle with ldr_gnt=1 and ldr_lock=1.
  - While locked, only ldr may be granted and starve_cnt does not saturate-override.
  - locked clears on the first edge where ldr_lock=0.
  - ldr_lock without ldr_req has no effect when unlocked.
- Reset (rst=1, synchronous):
  - All gnts=0, mem_en=0, mem_we=0, all rvalid=0 on the following cycle, tag=none, starve_cnt=0, locked=0.
  - rst is evaluated combinationally against grants: no grant is issued in any cycle rst=1.
  - A read granted in the cycle before rst asserts still returns rvalid in the rst cycle.
  - That read is dropped only if rst was high in its grant cycle.
- Simultaneous events: all three requesting with starve_cnt<STARVE_MAX → ldr granted; dmem and imem wait.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined:
  - Adds outputs ldr_cnt, dmem_cnt, imem_cnt (16 bits each) and stall_cnt (16 bits).
  - Each grant counter increments on its port's gnt.
  - stall_cnt increments each cycle imem_req=1 and imem_gnt=0.
  - All counters saturate at 16'hFFFF and clear on rst.
- Undefined: outputs and counters absent; arbitration behaviour identical.

Test Plan:
- Reset: hold rst 2 cycles with all reqs=1 → all gnt=0, mem_en=0, locked=0; first cycle after release grants ldr.
- Single fetch: imem_req=1, imem_addr=8'h05, memory[5]=16'h7888 → imem_gnt same cycle, imem_rvalid=1 with rdata=16'h7888 next cycle, dmem_rvalid=ldr_rvalid=0.
- Priority + starvation (STARVE_MAX=4): dmem_req and imem_req held high continuously → dmem granted 4 cycles, imem granted on the 5th, counter clears, then dmem resumes.
- Store then load: dmem ST addr 8'h16, data 16'd99; next cycle LD addr 8'h16 → no rvalid after the ST, dmem_rvalid with rdata=16'd99 one cycle after the LD grant.
- Loader lock: ldr_req=ldr_lock=1 writes 16 words while dmem_req/imem_req stay high → only ldr_gnt asserted, locked=1, no starvation override; ldr_lock=0 → imem (starved) granted first, then dmem.
- Reset mid-read: imem read granted cycle N, rst=1 cycle N+1 → imem_rvalid=1 in N+1, no grants in N+1, all rvalid=0 in N+2.
